sprite_motion_ctrl: RTL and testbench

Frame-synchronous motion controller for a single square sprite, sitting between game logic and the VGA driver. It updates the sprite position once per frame on the vsync leading edge and reflects it at the active-area bounds. It produces the per-pixel RGB565 colour fed to the driver's `rgb_i`. Updates are double-buffered, so a frame is never rendered with a half-updated position.

---
 rtl/vga_pkg.sv | 21 ++
 rtl/axis_reflect.sv | 45 ++++
 rtl/sprite_motion_ctrl.sv | 147 ++++++++++++++
 tb/tb_sprite_motion_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared colour constants and motion FSM encoding for the sprite path.
// Pure declarations: no logic, no latency.
package vga_pkg;

   localparam logic [15:0] BLACK   = 16'h0000;
   localparam logic [15:0] WHITE   = 16'hFFFF;
   localparam logic [15:0] RED     = 16'hF800;
   localparam logic [15:0] GREEN   = 16'h07E0;
   localparam logic [15:0] BLUE    = 16'h001F;
   localparam logic [15:0] YELLOW  = 16'hFFE0;
   localparam logic [15:0] MAGENTA = 16'hF81F;
   localparam logic [15:0] CYAN    = 16'h07FF;

   typedef enum logic [1:0] {
      IDLE,
      MOVE_X,
      MOVE_Y,
      COMMIT
   } motion_state_t;

endpackage

// File: rtl/axis_reflect.sv
// One-axis step with reflection at 0 and MAX; combinational, zero latency, no backpressure.
// dir = 1 means moving towards MAX.
module axis_reflect #(
   parameter int unsigned STEP = 2,
   parameter int unsigned MAX  = 636
) (
   input  logic [15:0] pos,
   input  logic        dir,
   output logic [15:0] next_pos,
   output logic        next_dir,
   output logic        flipped
);

   localparam logic [15:0] STEP_W = 16'(STEP);
   localparam logic [15:0] MAX_W  = 16'(MAX);

   logic [16:0] pos_up;

   // 17-bit sum so the upper bound check cannot wrap
   assign pos_up = {1'b0, pos} + {1'b0, STEP_W};

   always_comb begin
      next_pos = pos;
      next_dir = dir;
      flipped  = 1'b0;
      if (dir) begin
         if (pos_up >= {1'b0, MAX_W}) begin
            next_pos = MAX_W;
            next_dir = 1'b0;
            flipped  = 1'b1;
         end else begin
            next_pos = pos_up[15:0];
         end
      end else begin
         if (pos <= STEP_W) begin
            next_pos = 16'd0;
            next_dir = 1'b1;
            flipped  = 1'b1;
         end else begin
            next_pos = pos - STEP_W;
         end
      end
   end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Frame-synchronous sprite mover with double-buffered position and registered RGB565 output (1-cycle latency, no backpressure).
// Optional crosshair lines are drawn when SPRITE_CROSSHAIR_EN is defined.
module sprite_motion_ctrl
   import vga_pkg::*;
#(
   parameter int unsigned H_ACTIVE  = 640,
   parameter int unsigned V_ACTIVE  = 480,
   parameter int unsigned SIZE      = 4,
   parameter int unsigned H_INIT    = 128,
   parameter int unsigned V_INIT    = 128,
   parameter int unsigned STEP      = 2,
   parameter logic        VSYNC_POL = 1'b0
) (
   input  logic        clk_i,
   input  logic        reset_ni,
   input  logic        vsync_i,
   input  logic [15:0] hpos_i,
   input  logic [15:0] vpos_i,
   input  logic        enable_i,
   output logic [15:0] rgb_o,
   output logic [15:0] ball_x_o,
   output logic [15:0] ball_y_o,
   output logic        frame_tick_o,
   output logic        bounce_o
);

   localparam int unsigned X_MAX = H_ACTIVE - SIZE;
   localparam int unsigned Y_MAX = V_ACTIVE - SIZE;

   motion_state_t state, state_nxt;

   logic        vs_q;
   logic        frame_start;
   logic [15:0] ball_x, ball_y;
   logic        dx, dy;
   logic [15:0] nx, ny;
   logic        ndx, ndy;
   logic        flip_x, flip_y;
   logic [15:0] x_next, y_next;
   logic        x_dir_next, y_dir_next;
   logic        x_flip, y_flip;
   logic [16:0] x_end, y_end;
   logic        in_box;
   logic [15:0] pix;

   assign frame_start = (vsync_i == VSYNC_POL) && (vs_q != VSYNC_POL);

   axis_reflect #(.STEP(STEP), .MAX(X_MAX)) u_axis_x (
      .pos      (ball_x),
      .dir      (dx),
      .next_pos (x_next),
      .next_dir (x_dir_next),
      .flipped  (x_flip)
   );

   axis_reflect #(.STEP(STEP), .MAX(Y_MAX)) u_axis_y (
      .pos      (ball_y),
      .dir      (dy),
      .next_pos (y_next),
      .next_dir (y_dir_next),
      .flipped  (y_flip)
   );

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) state <= IDLE;
      else           state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (frame_start) state_nxt = MOVE_X;
         MOVE_X:  state_nxt = MOVE_Y;
         MOVE_Y:  state_nxt = COMMIT;
         COMMIT:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Shadow copies are only published in COMMIT, so a half-updated position is never visible
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         vs_q         <= ~VSYNC_POL;
         frame_tick_o <= 1'b0;
         bounce_o     <= 1'b0;
         ball_x       <= 16'(H_INIT);
         ball_y       <= 16'(V_INIT);
         dx           <= 1'b0;
         dy           <= 1'b1;
         nx           <= 16'(H_INIT);
         ny           <= 16'(V_INIT);
         ndx          <= 1'b0;
         ndy          <= 1'b1;
         flip_x       <= 1'b0;
         flip_y       <= 1'b0;
      end else begin
         vs_q         <= vsync_i;
         frame_tick_o <= frame_start && (state == IDLE);
         bounce_o     <= 1'b0;
         case (state)
            MOVE_X: begin
               nx     <= x_next;
               ndx    <= x_dir_next;
               flip_x <= x_flip;
            end
            MOVE_Y: begin
               ny     <= y_next;
               ndy    <= y_dir_next;
               flip_y <= y_flip;
            end
            COMMIT: begin
               if (enable_i) begin
                  ball_x   <= nx;
                  ball_y   <= ny;
                  dx       <= ndx;
                  dy       <= ndy;
                  bounce_o <= flip_x | flip_y;
               end
            end
            default: ;
         endcase
      end
   end

   assign x_end  = {1'b0, ball_x} + 17'(SIZE);
   assign y_end  = {1'b0, ball_y} + 17'(SIZE);
   assign in_box = (hpos_i >= ball_x) && ({1'b0, hpos_i} < x_end) &&
                   (vpos_i >= ball_y) && ({1'b0, vpos_i} < y_end);

   always_comb begin
      pix = BLACK;
      if (in_box) pix = WHITE;
`ifdef SPRITE_CROSSHAIR_EN
      else if (hpos_i == ball_x) pix = BLUE;
      else if (vpos_i == ball_y) pix = RED;
`endif
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) rgb_o <= BLACK;
      else           rgb_o <= pix;
   end

   assign ball_x_o = ball_x;
   assign ball_y_o = ball_y;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Randomised scoreboard bench for sprite_motion_ctrl with a frame-level reference model.
module tb_sprite_motion_ctrl;

   localparam int XMAX  = 636;
   localparam int YMAX  = 476;
   localparam int STEPV = 2;
   localparam int SZ    = 4;

   logic        clk = 1'b0;
   logic        reset_ni = 1'b0;
   logic        vsync_i = 1'b1;
   logic [15:0] hpos_i = 16'd1000;
   logic [15:0] vpos_i = 16'd1000;
   logic        enable_i = 1'b0;
   logic [15:0] rgb_o, ball_x_o, ball_y_o;
   logic        frame_tick_o, bounce_o;

   sprite_motion_ctrl dut (
      .clk_i        (clk),
      .reset_ni     (reset_ni),
      .vsync_i      (vsync_i),
      .hpos_i       (hpos_i),
      .vpos_i       (vpos_i),
      .enable_i     (enable_i),
      .rgb_o        (rgb_o),
      .ball_x_o     (ball_x_o),
      .ball_y_o     (ball_y_o),
      .frame_tick_o (frame_tick_o),
      .bounce_o     (bounce_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int x;
      int y;
      bit b;
      bit rst;
   } exp_t;

   typedef struct {
      int          stamp;
      logic [15:0] rgb;
   } pix_t;

   exp_t exp_q[$];
   pix_t pix_q[$];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   bit rst_event = 0;

   // reference model: committed position and direction (+1 / -1)
   int mx = 128, my = 128, mdx = -1, mdy = 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic axis_step(input int p, input int d, input int lim,
                            output int np, output int nd, output bit fl);
      np = p; nd = d; fl = 0;
      if (d > 0) begin
         if (p + STEPV >= lim) begin np = lim; nd = -1; fl = 1; end
         else np = p + STEPV;
      end else begin
         if (p <= STEPV) begin np = 0; nd = 1; fl = 1; end
         else np = p - STEPV;
      end
   endtask

   function automatic logic [15:0] ref_pix(input int h, input int v);
      if (h >= mx && h < mx + SZ && v >= my && v < my + SZ) return 16'hFFFF;
`ifdef SPRITE_CROSSHAIR_EN
      if (h == mx) return 16'h001F;
      if (v == my) return 16'hF800;
`endif
      return 16'h0000;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge reset_ni) rst_event = 1;

   // frame monitor: every frame_tick must match one queued expectation
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (frame_tick_o) begin
            chk("tick_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               rst_event = 0;
               @(negedge clk);
               chk("tick_width", 32'(frame_tick_o), 32'd0);
               chk("bounce_early", 32'(bounce_o), 32'd0);
               @(negedge clk);
               @(negedge clk);
               if (e.rst) begin
                  chk("reset_seen", 32'(rst_event), 32'd1);
                  chk("rst_x", 32'(ball_x_o), 32'd128);
                  chk("rst_y", 32'(ball_y_o), 32'd128);
                  chk("rst_bounce", 32'(bounce_o), 32'd0);
               end else begin
                  chk("ball_x", 32'(ball_x_o), 32'(e.x));
                  chk("ball_y", 32'(ball_y_o), 32'(e.y));
                  chk("bounce", 32'(bounce_o), 32'(e.b));
               end
               @(negedge clk);
               chk("bounce_width", 32'(bounce_o), 32'd0);
            end
         end
      end
   end

   // pixel monitor: entries driven before the last posedge are due now
   always @(negedge clk) begin
      while (pix_q.size() > 0 && pix_q[0].stamp < cyc) begin
         pix_t p;
         p = pix_q.pop_front();
         chk("rgb", 32'(rgb_o), 32'(p.rgb));
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic drive_pix(input int h, input int v);
      pix_t p;
      if (h < 0) h = 0;
      if (v < 0) v = 0;
      hpos_i = 16'(h);
      vpos_i = 16'(v);
      p.stamp = cyc;
      p.rgb   = ref_pix(h, v);
      pix_q.push_back(p);
      @(negedge clk);
   endtask

   task automatic run_frame(input bit en, input bit inject, input bit rst_mid, input int gap);
      exp_t e;
      int nx, ny, ndx, ndy;
      bit fx, fy;
      axis_step(mx, mdx, XMAX, nx, ndx, fx);
      axis_step(my, mdy, YMAX, ny, ndy, fy);
      e.rst = rst_mid;
      e.b   = 0;
      if (!rst_mid && en) begin
         mx = nx; my = ny; mdx = ndx; mdy = ndy;
         e.b = fx | fy;
      end
      e.x = mx;
      e.y = my;
      exp_q.push_back(e);
      enable_i = en;
      vsync_i  = 1'b0;
      @(negedge clk);
      if (inject) vsync_i = 1'b1;
      @(negedge clk);
      if (inject) vsync_i = 1'b0;
      if (rst_mid) reset_ni = 1'b0;
      repeat (3) @(negedge clk);
      vsync_i = 1'b1;
      if (rst_mid) begin
         reset_ni = 1'b1;
         mx = 128; my = 128; mdx = -1; mdy = 1;
      end
      repeat (gap) @(negedge clk);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("reset_x", 32'(ball_x_o), 32'd128);
      chk("reset_y", 32'(ball_y_o), 32'd128);
      chk("reset_rgb", 32'(rgb_o), 32'd0);
      chk("reset_tick", 32'(frame_tick_o), 32'd0);
      chk("reset_bounce", 32'(bounce_o), 32'd0);
      reset_ni = 1'b1;
      repeat (2) @(negedge clk);

      drive_pix(130, 129);
      drive_pix(128, 300);
      drive_pix(127, 128);
      drive_pix(131, 131);
      drive_pix(132, 128);
      drive_pix(128, 132);
      for (int i = 0; i < 40; i++)
         drive_pix(mx + int'($urandom_range(0, 9)) - 3, my + int'($urandom_range(0, 9)) - 3);
      hpos_i = 16'd1000;
      vpos_i = 16'd1000;
      repeat (2) @(negedge clk);

      run_frame(1'b1, 1'b0, 1'b0, 6);
      for (int i = 0; i < 3; i++) run_frame(1'b0, 1'b0, 1'b0, 6);
      run_frame(1'b1, 1'b1, 1'b0, 6);
      run_frame(1'b1, 1'b0, 1'b1, 6);
      run_frame(1'b1, 1'b0, 1'b0, 6);

      for (int i = 0; i < 450; i++)
         run_frame(($urandom % 10) != 0, ($urandom % 8) == 0, 1'b0,
                   int'($urandom_range(5, 9)));

      for (int i = 0; i < 120; i++) begin
         if (($urandom % 4) == 0)
            drive_pix(int'($urandom_range(0, 700)), int'($urandom_range(0, 520)));
         else
            drive_pix(mx + int'($urandom_range(0, 9)) - 3, my + int'($urandom_range(0, 9)) - 3);
      end
      hpos_i = 16'd1000;
      vpos_i = 16'd1000;
      repeat (4) @(negedge clk);

      chk("frames_left", 32'(exp_q.size()), 32'd0);
      chk("pixels_left", 32'(pix_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
